// File: rtl/switch_emu_defs_pkg.sv
// rtl/switch_emu_defs_pkg.sv - shared state encoding and LFSR constants for switch emulators
//
// Purpose: state encoding, default LFSR tap mask/seed and the LFSR step
// function, shared by the single-switch emulator and any future multi-switch
// variant.
package switch_emu_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS_BNC = 3'd1,
        ST_HOLD      = 3'd2,
        ST_REL_BNC   = 3'd3,
        ST_SETTLE    = 3'd4
    } state_t;

    // Taps x^16 + x^14 + x^13 + x^11 + 1 map to bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Fibonacci step: shift left, XOR of tapped bits enters at bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] value,
                                              input logic [15:0] mask);
        return {value[14:0], ^(value & mask)};
    endfunction

endpackage

// File: rtl/switch_bounce_gen_lfsr16.sv
// rtl/switch_bounce_gen_lfsr16.sv - 16-bit Fibonacci LFSR that advances only on request
//
// Purpose: pseudo-random source for bounce segment lengths.
// Ports:
//   i_Clk    system clock
//   i_Rst    asynchronous active-high reset, loads SEED (0 is forced to 1)
//   i_Step   advance one step on this edge
//   o_Value  current LFSR state
module lfsr16
    import switch_emu_defs::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Step,
    output logic [15:0] o_Value
);

    // An all-zero state would lock the register, so a zero seed becomes 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Value <= SEED_EFF;
        end else if (i_Step) begin
            o_Value <= lfsr_next(o_Value, LFSR_TAP_MASK);
        end
    end

endmodule

// File: rtl/switch_bounce_gen.sv
// rtl/switch_bounce_gen.sv - mechanical switch emulator producing a bouncing press/release waveform
//
// Purpose: on a press request, emit a bouncing rising edge, a stable high hold,
// a bouncing falling edge and a stable low settle period, then pulse o_Done.
// Ports:
//   i_Clk        system clock
//   i_Rst        asynchronous active-high reset
//   i_Press_Req  start one press/release cycle (sampled only when idle)
//   o_Switch     emulated raw switch level, registered (1 = pressed)
//   o_Busy       high whenever a cycle is in progress
//   o_Done       one-cycle pulse, coincident with the return to idle
module switch_bounce_gen
    import switch_emu_defs::*;
#(
    parameter int          BOUNCE_COUNT = 6,
    parameter int          GLITCH_W     = 10,
    parameter int          HOLD_CLKS    = 500000,
    parameter int          SETTLE_CLKS  = 250000,
    parameter logic [15:0] LFSR_SEED    = LFSR_DEFAULT_SEED
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Press_Req,
    output logic o_Switch,
    output logic o_Busy,
    output logic o_Done
);

    localparam int LONG_CLKS = (HOLD_CLKS > SETTLE_CLKS) ? HOLD_CLKS : SETTLE_CLKS;
    localparam int LONG_W    = (LONG_CLKS > 1) ? $clog2(LONG_CLKS) : 1;
    localparam int IDX_W     = (BOUNCE_COUNT > 1) ? $clog2(BOUNCE_COUNT) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(BOUNCE_COUNT - 1);
    localparam logic [LONG_W-1:0] HOLD_LOAD   = LONG_W'(HOLD_CLKS - 1);
    localparam logic [LONG_W-1:0] SETTLE_LOAD = LONG_W'(SETTLE_CLKS - 1);

    state_t              state;
    logic [GLITCH_W-1:0] seg_cnt;
    logic [IDX_W-1:0]    bnc_idx;
    logic [IDX_W-1:0]    idx_next;
    logic [LONG_W-1:0]   long_cnt;
    logic [15:0]         lfsr_val;
    logic                lfsr_step;
    logic [GLITCH_W-1:0] seg_load;
    logic                unused_lfsr_bits;

    // Counters run down to zero, so a segment of length lfsr+1 loads lfsr itself.
    assign seg_load         = lfsr_val[GLITCH_W-1:0];
    assign idx_next         = bnc_idx + 1'b1;
    assign unused_lfsr_bits = ^(lfsr_val >> GLITCH_W);

    // The LFSR advances exactly when a new segment length is consumed.
    always_comb begin
        lfsr_step = 1'b0;
        case (state)
            ST_IDLE:                  lfsr_step = i_Press_Req;
            ST_PRESS_BNC, ST_REL_BNC: lfsr_step = (seg_cnt == '0) && (bnc_idx != LAST_IDX);
            ST_HOLD:                  lfsr_step = (long_cnt == '0);
            default:                  lfsr_step = 1'b0;
        endcase
    end

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Step (lfsr_step),
        .o_Value(lfsr_val)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state    <= ST_IDLE;
            o_Switch <= 1'b0;
            o_Busy   <= 1'b0;
            o_Done   <= 1'b0;
            seg_cnt  <= '0;
            bnc_idx  <= '0;
            long_cnt <= '0;
        end else begin
            o_Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_Press_Req) begin
                        state    <= ST_PRESS_BNC;
                        o_Switch <= 1'b1;
                        o_Busy   <= 1'b1;
                        bnc_idx  <= '0;
                        seg_cnt  <= seg_load;
                    end
                end
                // Even segments sit at the target level (1), odd ones at its inverse.
                ST_PRESS_BNC: begin
                    if (seg_cnt != '0) begin
                        seg_cnt <= seg_cnt - 1'b1;
                    end else if (bnc_idx == LAST_IDX) begin
                        state    <= ST_HOLD;
                        o_Switch <= 1'b1;
                        long_cnt <= HOLD_LOAD;
                    end else begin
                        bnc_idx  <= idx_next;
                        seg_cnt  <= seg_load;
                        o_Switch <= ~idx_next[0];
                    end
                end
                ST_HOLD: begin
                    if (long_cnt != '0) begin
                        long_cnt <= long_cnt - 1'b1;
                    end else begin
                        state    <= ST_REL_BNC;
                        bnc_idx  <= '0;
                        seg_cnt  <= seg_load;
                        o_Switch <= 1'b0;
                    end
                end
                // Target level is 0 here, so odd segments are the high glitches.
                ST_REL_BNC: begin
                    if (seg_cnt != '0) begin
                        seg_cnt <= seg_cnt - 1'b1;
                    end else if (bnc_idx == LAST_IDX) begin
                        state    <= ST_SETTLE;
                        o_Switch <= 1'b0;
                        long_cnt <= SETTLE_LOAD;
                    end else begin
                        bnc_idx  <= idx_next;
                        seg_cnt  <= seg_load;
                        o_Switch <= idx_next[0];
                    end
                end
                ST_SETTLE: begin
                    if (long_cnt != '0) begin
                        long_cnt <= long_cnt - 1'b1;
                    end else begin
                        state  <= ST_IDLE;
                        o_Busy <= 1'b0;
                        o_Done <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    o_Switch <= 1'b0;
                    o_Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_bounce_gen.sv
// tb/tb_switch_bounce_gen.sv - self-checking bench for switch_bounce_gen
module tb_switch_bounce_gen;

    localparam int BC        = 4;
    localparam int GW        = 3;
    localparam int HOLD      = 100;
    localparam int SETTLE    = 50;
    localparam int DB_LIMIT  = 20;
    localparam int ABORT_AT  = 40;

    logic clk = 1'b0;
    logic rst;
    logic req1, req2;
    logic sw1, busy1, done1;
    logic sw2, busy2, done2;

    always #5 clk = ~clk;

    switch_bounce_gen #(
        .BOUNCE_COUNT(BC), .GLITCH_W(GW), .HOLD_CLKS(HOLD),
        .SETTLE_CLKS(SETTLE), .LFSR_SEED(16'hACE1)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Press_Req(req1),
        .o_Switch(sw1), .o_Busy(busy1), .o_Done(done1)
    );

    switch_bounce_gen #(
        .BOUNCE_COUNT(BC), .GLITCH_W(GW), .HOLD_CLKS(HOLD),
        .SETTLE_CLKS(SETTLE), .LFSR_SEED(16'h0000)
    ) dut_zero_seed (
        .i_Clk(clk), .i_Rst(rst), .i_Press_Req(req2),
        .o_Switch(sw2), .o_Busy(busy2), .o_Done(done2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    int   sel_dut = 0;
    logic cur_sw, cur_busy, cur_done;
    assign cur_sw   = (sel_dut == 1) ? sw2   : sw1;
    assign cur_busy = (sel_dut == 1) ? busy2 : busy1;
    assign cur_done = (sel_dut == 1) ? done2 : done1;

    task automatic set_req(input bit r);
        req1 = (sel_dut == 0) ? r : 1'b0;
        req2 = (sel_dut == 1) ? r : 1'b0;
    endtask

    // Reference model: LFSR state per DUT and the expected per-cycle trace.
    logic [15:0] m_lfsr [2];
    bit exp_sw[$];
    bit exp_busy[$];
    bit exp_done[$];
    int m_press_total;

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    task automatic push_cycles(input int n, input bit s, input bit b, input bit d);
        for (int c = 0; c < n; c++) begin
            exp_sw.push_back(s);
            exp_busy.push_back(b);
            exp_done.push_back(d);
        end
    endtask

    task automatic build(input int sel);
        int len;
        exp_sw.delete(); exp_busy.delete(); exp_done.delete();
        m_press_total = 0;
        for (int phase = 0; phase < 2; phase++) begin
            for (int k = 0; k < BC; k++) begin
                len = int'(m_lfsr[sel] % (1 << GW)) + 1;
                m_lfsr[sel] = ref_step(m_lfsr[sel]);
                // press: even segments high; release: odd segments high
                push_cycles(len, (phase == 0) ? (k % 2 == 0) : (k % 2 == 1), 1'b1, 1'b0);
                if (phase == 0) m_press_total += len;
            end
            if (phase == 0) push_cycles(HOLD, 1'b1, 1'b1, 1'b0);
            else            push_cycles(SETTLE, 1'b0, 1'b1, 1'b0);
        end
        push_cycles(1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic reset_models();
        m_lfsr[0] = 16'hACE1;
        m_lfsr[1] = 16'h0001;
    endtask

    // Caller has set the request at a negedge; compares the full trace.
    // abort_hold >= 1 asserts reset asynchronously in that cycle of HOLD.
    task automatic play(input bit chain, input int abort_hold);
        int n, abort_idx;
        build(sel_dut);
        n = exp_sw.size();
        abort_idx = (abort_hold > 0) ? m_press_total + abort_hold - 1 : -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("sw",   int'(cur_sw),   int'(exp_sw[i]));
            check("busy", int'(cur_busy), int'(exp_busy[i]));
            check("done", int'(cur_done), int'(exp_done[i]));
            if (i == abort_idx) begin
                #2 rst = 1'b1;
                set_req(1'b0);
                #1;
                check("abort_sw",   int'(cur_sw),   0);
                check("abort_busy", int'(cur_busy), 0);
                reset_models();
                @(negedge clk);
                check("abort_done", int'(cur_done), 0);
                rst = 1'b0;
                return;
            end
            set_req((i == n - 1) ? chain : 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic idle(input int n);
        set_req(1'b0);
        repeat (n) begin
            @(negedge clk);
            check("idle_sw",   int'(cur_sw),   0);
            check("idle_busy", int'(cur_busy), 0);
            check("idle_done", int'(cur_done), 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_req(1'b0);
        rst = 1'b1;
        #1;
        check("rst_sw",   int'(cur_sw),   0);
        check("rst_busy", int'(cur_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        reset_models();
    endtask

    // Debouncer + LED toggle on debounced release, driven from the main DUT.
    logic db_state, led;
    int   db_cnt, toggles;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            db_state <= 1'b0; db_cnt <= 0; led <= 1'b0; toggles <= 0;
        end else if (sw1 != db_state) begin
            if (db_cnt == DB_LIMIT - 1) begin
                db_state <= sw1;
                db_cnt   <= 0;
                if (db_state) begin
                    led     <= ~led;
                    toggles <= toggles + 1;
                end
            end else begin
                db_cnt <= db_cnt + 1;
            end
        end else begin
            db_cnt <= 0;
        end
    end

    initial begin
        rst = 1'b1; req1 = 1'b0; req2 = 1'b0;
        reset_models();
        repeat (3) @(negedge clk);
        check("reset_sw",    int'(sw1),   0);
        check("reset_busy",  int'(busy1), 0);
        check("reset_done",  int'(done1), 0);
        check("reset_sw_z",  int'(sw2),   0);
        check("reset_busy_z",int'(busy2), 0);
        rst = 1'b0;
        idle(3);

        // single request, then a replay after reset
        set_req(1'b1); play(1'b0, 0);
        idle(int'($urandom_range(2, 6)));
        do_reset();
        set_req(1'b1); play(1'b0, 0);
        idle(3);

        // back-to-back requests with request held asserted
        set_req(1'b1);
        play(1'b1, 0); play(1'b1, 0); play(1'b0, 0);
        idle(5);

        // reset in the middle of HOLD, then a replay from the seed
        set_req(1'b1); play(1'b0, ABORT_AT);
        idle(4);
        set_req(1'b1); play(1'b0, 0);
        idle(2);

        // debounced LED toggles once per release
        do_reset();
        check("led_init", int'(led), 0);
        for (int r = 0; r < 3; r++) begin
            set_req(1'b1); play(1'b0, 0);
            idle(int'($urandom_range(1, 5)));
            check("led_toggles", toggles, r + 1);
            check("led_level",   int'(led), (r % 2 == 0) ? 1 : 0);
        end

        // random gaps and chaining on the main DUT
        for (int r = 0; r < 3; r++) begin
            idle(int'($urandom_range(1, 8)));
            set_req(1'b1); play(1'b0, 0);
        end
        idle(2);

        // zero seed behaves as seed 1
        sel_dut = 1;
        do_reset();
        set_req(1'b1); play(1'b0, 0);
        set_req(1'b1); play(1'b0, 0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/switch_bounce_gen.md
Name: switch_bounce_gen

Overview:
Synthesizable mechanical-switch emulator: the driving end of the debounced-switch path. On a press request it emits a switch waveform that bounces, holds high, bounces on release and settles low. The pattern is pseudo-random but reproducible. Used for on-board self-test of Debounce_Switch and the falling-edge LED-toggle logic; its o_Switch replaces a physical i_Switch_N input.

Parameters:
BOUNCE_COUNT, 6, number of bounce segments per edge (press and release); must be ≥1
GLITCH_W, 10, width of each segment's random length; segment length = (lfsr[GLITCH_W-1:0]) + 1, so 1..2^GLITCH_W clocks
HOLD_CLKS, 500000, clocks o_Switch is held stable high between press and release bounce (20 ms at 25 MHz)
SETTLE_CLKS, 250000, clocks of stable low after release before o_Done
LFSR_SEED, 16'hACE1, LFSR reset value; 16'h0000 is replaced by 16'h0001

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  asynchronous, active-high reset
i_Press_Req  in  1  start one press/release cycle; sampled only in IDLE
o_Switch  out  1  emulated raw switch level (1 = pressed)
o_Busy  out  1  high in every state except IDLE
o_Done  out  1  one-cycle pulse when the cycle completes

Behaviour:
- Reset (async, i_Rst=1): state IDLE, o_Switch=0, o_Busy=0, o_Done=0, segment counter 0, bounce index 0, LFSR=LFSR_SEED.
- States: IDLE, PRESS_BNC, HOLD, REL_BNC, SETTLE.
- IDLE:
  - i_Press_Req=1 at edge → PRESS_BNC next cycle with bounce index k=0.
  - Segment length is loaded from the LFSR; the LFSR advances one step.
  - o_Switch=1 and o_Busy=1 appear on the cycle after i_Press_Req is sampled (latency 1).
- PRESS_BNC (target level T=1):
  - During segment k, o_Switch = T if k even, ~T if k odd.
  - When a segment counter expires: k increments, the next length is loaded, and the LFSR steps.
  - After segment BOUNCE_COUNT-1 expires → HOLD with o_Switch=1.
- HOLD: o_Switch=1 for exactly HOLD_CLKS cycles → REL_BNC, k=0, T=0. REL_BNC uses the same segment rules as PRESS_BNC.
- REL_BNC end → SETTLE: o_Switch=0 for SETTLE_CLKS cycles. On the last cycle, o_Done=1 for one cycle, and IDLE is re-entered with o_Busy=0 in the same cycle o_Done is high.
- Net result per request: exactly one clean rising level (after press bounce) and one clean falling level (after release bounce).
- i_Press_Req while o_Busy=1: ignored, not queued.
- i_Press_Req high in the cycle IDLE is re-entered: starts a new cycle on the next edge.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift-left, feedback into bit 0.
  - Steps only on segment loads, so the waveform is identical for a given seed and request sequence.
- Counters are sized with $clog2 of the largest count. No arithmetic wrap occurs: each counter reloads on expiry.
- Reset mid-operation: immediate return to the reset values above. No o_Done is generated for the aborted cycle.
- o_Switch is registered (no glitches) and safe to feed directly into Debounce_Switch.

Decomposition:
- Shared package/header switch_emu_defs: state encoding localparams (IDLE..SETTLE, 3-bit) and the default LFSR tap mask/seed constant, so a future multi-switch emulator reuses them.
- One sub-module, lfsr16:
  - i_Clk, i_Rst, i_Step, o_Value[15:0]
  - seed parameter, async reset
- The FSM, segment counter and hold/settle counter stay in switch_bounce_gen.

Test Plan:
Common bench parameters: BOUNCE_COUNT=4, GLITCH_W=3, HOLD_CLKS=100, SETTLE_CLKS=50, seed 16'hACE1.
1. Single request → o_Switch rises 1 cycle after the req edge. Exactly 4 segments per bounce phase, each 1..8 cycles. Stable high for exactly 100 cycles. 4 release segments, then stable low 50 cycles. o_Done high one cycle. o_Busy falls the same cycle.
2. Golden determinism: two runs, reset between them → bit-identical o_Switch traces. Segment lengths match the reference-model LFSR sequence from 16'hACE1.
3. Request spam: i_Press_Req held high for 1000 cycles → back-to-back cycles, none overlapping. Each starts the cycle after the prior o_Done. o_Done count = completed cycles.
4. Reset mid-HOLD (cycle 40 of HOLD) → o_Switch=0, o_Busy=0 asynchronously. No o_Done. The next request replays the waveform from the seed.
5. System check: drive Debounce_Switch (stable-count limit 20) plus the LED toggle logic from o_Switch, then issue 3 requests → LED toggles exactly 3 times (0→1→0→1), once per release. No toggles during bounce.
6. Seed 16'h0000 → behaves as seed 16'h0001. The LFSR never locks at zero; all segment lengths stay ≥1.
